// File: rtl/bitslam_reg_writer.sv
// bitslam_reg_writer: buffers (addr, data) write requests and serialises them as
// address/data beats on the bitslam voice register bus, skipping repeated addresses.
module bitslam_reg_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter bit ADDR_CACHE = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [5:0]                    req_addr,
  input  logic [5:0]                    req_data,
  output logic                          bus_sel,
  output logic [5:0]                    bus_addr_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_n;
  logic [11:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [5:0] cur_addr, cur_data, last_addr;
  logic [5:0] cur_addr_n, cur_data_n, last_n;
  logic cache_valid, cv_n, push, pop;
  logic [LW-1:0] level_n;
  always_comb begin
    push = req_valid && req_ready;
    pop = (state != ADDR) && (fifo_level != '0);
    level_n = fifo_level + LW'(push) - LW'(pop);
    cur_addr_n = pop ? mem[rd_ptr][11:6] : cur_addr;
    cur_data_n = pop ? mem[rd_ptr][5:0] : cur_data;
    last_n = (state == ADDR) ? cur_addr : last_addr;
    cv_n = cache_valid || (state == ADDR);
    // A repeated address goes straight to the data beat; the target still holds it
    state_n = pop ? ((ADDR_CACHE && cache_valid && cur_addr_n == last_addr) ? DATA : ADDR)
                  : (state == ADDR ? DATA : IDLE);
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {req_addr, req_data};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      req_ready <= 1'b1;
      cur_addr <= '0;
      cur_data <= '0;
      last_addr <= '0;
      cache_valid <= 1'b0;
      bus_sel <= 1'b0;
      bus_addr_data <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      fifo_level <= level_n;
      req_ready <= level_n != LW'(FIFO_DEPTH);
      cur_addr <= cur_addr_n;
      cur_data <= cur_data_n;
      last_addr <= last_n;
      cache_valid <= cv_n;
      bus_sel <= state_n == DATA;
      bus_addr_data <= state_n == DATA ? cur_data_n : state_n == ADDR ? cur_addr_n : last_n;
      busy <= (state_n != IDLE) || (level_n != '0);
    end
  end
endmodule
